bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Sits directly downstream of the combinational x3 stage and consumes its
//   6-bit product (0..45) to produce decimal digits for the board display.
//   Valid/ready handshake on both sides. One conversion in flight at a time.
// PARAMETERS
//   IN_W    6  width of binary input; range 1..16
//   DIGITS  2  number of BCD output digits; must satisfy 10**DIGITS > 2**IN_W-1
// PORTS
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          in_data valid
//   in_ready   out  1          block can accept; high only in IDLE
//   in_data    in   IN_W       unsigned binary value
//   out_valid  out  1          bcd valid; held until out_ready
//   out_ready  in   1          consumer accepts bcd
//   bcd        out  4*DIGITS   digit i = bcd[4i+3:4i]; digit 0 = units
//   seg        out  7*DIGITS   (SEVEN_SEG_EN only) active-low {g..a} per digit
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, in_ready=1 after release,
//     out_valid=0, bcd=0, seg=all 1s (blank), bit counter=0, shift reg=0.
//   FSM: IDLE -> CONV -> DONE -> IDLE.
//   IDLE: in_ready=1. Transfer on clk edge with in_valid&in_ready: capture
//     in_data into binary shift reg, clear BCD accumulator, cnt=0 -> CONV.
//   CONV: in_ready=0. Each edge: every BCD nibble >=5 gets +3 (all nibbles
//     in parallel, same cycle), then {bcd_acc,bin} shifts left 1; cnt++.
//     On the edge where cnt==IN_W-1: bcd output reg loaded -> DONE.
//   DONE: out_valid=1, bcd stable. Edge with out_ready=1 -> IDLE,
//     out_valid=0. out_ready=0 holds DONE indefinitely, bcd unchanged.
//   Latency: out_valid rises exactly IN_W edges after the accepting edge.
//   Throughput: one conversion per IN_W+2 cycles with out_ready tied high.
//   in_valid while in CONV/DONE is ignored (no capture, no side effect).
//   out_ready outside DONE has no effect. in_data=0 -> all digits 0.
//   Max input 2**IN_W-1 must convert exactly; no overflow flag.
//   Width rules: nibble add is 4-bit; shift reg width = 4*DIGITS+IN_W.
//   Reset asserted mid-CONV or in DONE: conversion discarded, immediate
//     return to reset values; no partial result ever presented.
// CONFIGURATION
//   BIN_TO_BCD_SEVEN_SEG_EN defined: port seg present; each digit decoded
//     to active-low 7-seg, registered, updated on the same edge as bcd
//     (valid when out_valid=1); values 10..15 decode blank.
//   Not defined: port seg absent, no decoder logic; all else identical.
// STRUCTURE
//   Shared package/header: state encodings ST_IDLE/ST_CONV/ST_DONE,
//     BCD_ADJ_THRESH=5, BCD_ADJ_ADD=3, 7-seg digit pattern constants.
//   Sub-module: bcd_seg7_decode (one nibble -> 7 active-low segments,
//     combinational), instantiated DIGITS times under the macro.
//   Top holds FSM, counter, shift reg, output regs.
// TESTING
//   Reset, then in_data=45 accepted -> 6 edges later out_valid=1, bcd=8'h45;
//     with macro, seg = {digit4,digit5} patterns.
//   in_data=0 -> bcd=8'h00; in_data=63 -> bcd=8'h63; sweep 0..63 vs model.
//   out_ready=0 for 10 cycles in DONE -> out_valid, bcd stable; in_ready=0.
//   in_valid=1 with new data during CONV -> ignored, result of first value.
//   rst_n pulse low mid-CONV -> out_valid=0, bcd=0, in_ready=1 after release.
//   out_ready tied 1, in_valid tied 1 -> one result every 8 cycles.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared encodings for the sequential binary-to-BCD converter: FSM states,
// double-dabble adjust constants and active-low 7-segment {g..a} patterns.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Nibble correction applied before each shift; stays within 4 bits.
  function automatic logic [3:0] bcd_adj(input logic [3:0] nib);
    return (nib >= BCD_ADJ_THRESH) ? nib + BCD_ADJ_ADD : nib;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_seg7_decode.sv
// One BCD nibble to active-low 7-segment {g..a}; codes 10..15 show blank.
module bcd_seg7_decode
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional registered 7-segment outputs when BIN_TO_BCD_SEVEN_SEG_EN is defined.
//
//   state   | meaning
//   IDLE    | in_ready=1, waiting for in_valid
//   CONV    | adjusting and shifting one bit per edge
//   DONE    | out_valid=1, result held until out_ready
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN_TO_BCD_SEVEN_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);

  localparam int SH_W  = 4*DIGITS + IN_W;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   sh;
  logic [SH_W-1:0]   sh_adj;
  logic [SH_W-1:0]   sh_next;

  // All digits adjusted in parallel, then the whole {bcd_acc,bin} shifts once.
  always_comb begin
    sh_adj = sh;
    for (int i = 0; i < DIGITS; i++) begin
      sh_adj[IN_W + 4*i +: 4] = bcd_adj(sh[IN_W + 4*i +: 4]);
    end
    sh_next = {sh_adj[SH_W-2:0], 1'b0};
  end

`ifdef BIN_TO_BCD_SEVEN_SEG_EN
  logic [7*DIGITS-1:0] seg_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_seg7_decode u_dec (
      .digit (sh_next[SH_W - 4*DIGITS + 4*g +: 4]),
      .seg   (seg_next[7*g +: 7])
    );
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd       <= '0;
      cnt       <= '0;
      sh        <= '0;
`ifdef BIN_TO_BCD_SEVEN_SEG_EN
      seg       <= '1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sh       <= {{(4*DIGITS){1'b0}}, in_data};
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          sh  <= sh_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            bcd       <= sh_next[SH_W-1 -: 4*DIGITS];
`ifdef BIN_TO_BCD_SEVEN_SEG_EN
            seg       <= seg_next;
`endif
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (IN_W=6, DIGITS=2).
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] bcd;
`ifdef BIN_TO_BCD_SEVEN_SEG_EN
  logic [13:0] seg;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.IN_W(6), .DIGITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
`ifdef BIN_TO_BCD_SEVEN_SEG_EN
    ,
    .seg       (seg)
`endif
  );

  function automatic logic [7:0] exp_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Drive one accepted transfer; returns at the negedge right after the accepting edge.
  task automatic start(input logic [5:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges counted from the accepting edge until out_valid; -1 if it never came.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 30) begin
      @(negedge clk);
      edges++;
    end
    if (!out_valid) edges = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (bcd !== 8'h00) begin errors++; $display("FAIL reset_bcd got=%h exp=00", bcd); end
`ifdef BIN_TO_BCD_SEVEN_SEG_EN
    checks++;
    if (seg !== 14'h3FFF) begin errors++; $display("FAIL reset_seg got=%h exp=3fff", seg); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_latency_45();
    int edges;
    start(6'd45);
    wait_valid(edges);
    checks++;
    if (edges != 6) begin errors++; $display("FAIL latency_45 got=%0d exp=6", edges); end
    checks++;
    if (bcd !== 8'h45) begin errors++; $display("FAIL bcd_45 got=%h exp=45", bcd); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_done got=%b exp=0", in_ready); end
`ifdef BIN_TO_BCD_SEVEN_SEG_EN
    checks++;
    if (seg !== {7'h19, 7'h12}) begin errors++; $display("FAIL seg_45 got=%h exp=%h", seg, {7'h19, 7'h12}); end
`endif
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL release_45 out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_max();
    int edges;
    start(6'd0);
    wait_valid(edges);
    checks++;
    if (edges != 6 || bcd !== 8'h00) begin errors++; $display("FAIL zero got=%h lat=%0d exp=00 lat=6", bcd, edges); end
    release_out();
    start(6'd63);
    wait_valid(edges);
    checks++;
    if (edges != 6 || bcd !== 8'h63) begin errors++; $display("FAIL max got=%h lat=%0d exp=63 lat=6", bcd, edges); end
    release_out();
  endtask

  task automatic test_sweep();
    int edges;
    for (int v = 0; v < 64; v++) begin
      start(6'(v));
      wait_valid(edges);
      checks++;
      if (edges != 6 || bcd !== exp_bcd(v)) begin
        errors++; $display("FAIL sweep_%0d got=%h lat=%0d exp=%h", v, bcd, edges, exp_bcd(v));
      end
      release_out();
    end
  endtask

  task automatic test_hold();
    int edges;
    int bad;
    start(6'd27);
    wait_valid(edges);
    checks++;
    if (edges != 6) begin errors++; $display("FAIL hold_latency got=%0d exp=6", edges); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 6'd9;
      @(negedge clk);
      if (out_valid !== 1'b1 || bcd !== 8'h27 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable bad_cycles=%0d exp=0 bcd=%h", bad, bcd); end
    release_out();
  endtask

  task automatic test_ignore_in_conv();
    int edges;
    start(6'd12);
    in_valid = 1'b1;
    in_data  = 6'd50;
    wait_valid(edges);
    checks++;
    if (edges != 6 || bcd !== 8'h12) begin errors++; $display("FAIL ignore_conv got=%h lat=%0d exp=12 lat=6", bcd, edges); end
    in_valid = 1'b0;
    release_out();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ignore_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_conv();
    int edges;
    int bad;
    start(6'd39);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || bcd !== 8'h00 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid got out_valid=%b bcd=%h in_ready=%b exp 0/00/1", out_valid, bcd, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_no_partial bad_cycles=%0d exp=0", bad); end
    start(6'd39);
    wait_valid(edges);
    checks++;
    if (edges != 6 || bcd !== 8'h39) begin errors++; $display("FAIL after_reset got=%h lat=%0d exp=39 lat=6", bcd, edges); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int last;
    int hits;
    int bad_gap;
    int bad_val;
    last = -1; hits = 0; bad_gap = 0; bad_val = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 6'd58;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (bcd !== 8'h58) bad_val++;
        if (last >= 0 && i - last != 8) bad_gap++;
        last = i;
        hits++;
      end
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (hits < 5) begin errors++; $display("FAIL b2b_count got=%0d exp>=5", hits); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL b2b_period bad_gaps=%0d exp=0", bad_gap); end
    checks++;
    if (bad_val != 0) begin errors++; $display("FAIL b2b_value bad=%0d exp=0", bad_val); end
  endtask

  initial begin
    test_reset();
    test_latency_45();
    test_zero_max();
    test_sweep();
    test_hold();
    test_ignore_in_conv();
    test_reset_mid_conv();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
